multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing FSM for the MIPS core.
- Consumes the 8-bit decoded control bundle plus reg_res from the instruction decoder, the ALU zero flag, and a memory ready handshake.
- Drives per-cycle datapath enables: PC, IR, ALU, memory and register file.
- Adds a memory-wait watchdog, an illegal-instruction fault and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory request may wait for mem_ready before a fault; legal range 2..255.
- RETIRE_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- signals  in  8  decoded bundle: [7]ALUSrc [6]MemToReg [5]RegWrite [4]MemRead [3]MemWrite [2]branch [1]eq [0]goto.
- reg_res  in  1  destination select from the decoder.
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_write  out  1  load PC.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- ir_write  out  1  load IR.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- alu_src  out  1  ALU B = immediate.
- alu_sub  out  1  force subtract (branch compare).
- reg_write  out  1  register-file write.
- mem_to_reg  out  1  write-back from memory data.
- reg_dst  out  1  copy of latched reg_res.
- fault  out  1  sticky fault.
- fault_cause  out  2  01 = illegal, 10 = memory timeout.
- retired  out  RETIRE_W  instructions completed.
- state  out  4  current state, for debug.

Behaviour:
- Reset: state = FETCH, wait counter = 0, retired = 0, fault = 0, fault_cause = 00, latched bundle = 0, latched reg_res = 0. All outputs are 0 in the cycle following reset except mem_req, which FETCH drives.
- Rule for every state: any output not named for that state is 0.
- FETCH: mem_req = 1, addr_sel = 0, mem_we = 0.
  - If mem_ready: ir_write = 1, pc_write = 1, pc_src = 0, next DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE (1 cycle): latch signals and reg_res. Priority order:
  - goto → JUMP
  - branch → BRANCH
  - MemRead or MemWrite → ADDR
  - RegWrite → EXEC
  - otherwise FAULT with cause 01.
- EXEC: alu_src = latched[7]; next WB.
- ADDR: alu_src = 1; next MEM.
- MEM: mem_req = 1, addr_sel = 1, mem_we = latched[3].
  - On mem_ready with MemRead: next WB.
  - On mem_ready without MemRead (store): retire, next FETCH.
  - Otherwise stay and count.
- WB: reg_write = 1, mem_to_reg = latched[6], reg_dst = latched reg_res; retire, next FETCH.
- BRANCH: alu_sub = 1, pc_src = 1, pc_write = latched[1] ? alu_zero : ~alu_zero (Mealy on alu_zero); retire, next FETCH.
- JUMP: pc_src = 2, pc_write = 1; retire, next FETCH.
- FAULT: fault = 1, cause held, all other outputs 0, retired frozen. Only rst exits FAULT.
- Wait counter:
  - Clears on every state transition.
  - Counts only in FETCH and MEM while mem_ready = 0.
  - If the counter equals MEM_TIMEOUT-1 and mem_ready = 0 → FAULT with cause 10.
  - mem_ready in that same cycle wins over timeout.
- Retire: retired += 1 on the retiring transition; wraps from all-ones to 0.
- mem_req stays asserted continuously while waiting; the request never drops before mem_ready.
- Reset mid-operation: rst overrides all transitions, including FAULT and a pending memory wait. mem_req deasserts after the reset edge only if the next state is not FETCH; in practice it stays asserted because FETCH follows reset.
- Latencies, all with immediate mem_ready:
  - R-type / addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq / bne / j: 3 cycles.

Decomposition:
- Shared include mips_ctrl_defs.vh holds:
  - state encodings: FETCH = 0, DECODE = 1, EXEC = 2, ADDR = 3, MEM = 4, WB = 5, BRANCH = 6, JUMP = 7, FAULT = 8;
  - signal bit indices;
  - pc_src codes;
  - fault cause codes.
- One sub-module, mc_wait_timer: wait counter with clear/enable inputs and an expired flag, parameterised by MEM_TIMEOUT.

Test Plan:
- R-type bundle 00100000, reg_res = 1, mem_ready tied 1:
  - FETCH→DECODE→EXEC→WB→FETCH.
  - reg_write = 1 and reg_dst = 1 in WB only.
  - retired = 1 after 4 cycles.
- lw bundle 11110000, mem_ready low 3 cycles in MEM:
  - MEM held 4 cycles with mem_req = 1, mem_we = 0, addr_sel = 1.
  - WB has mem_to_reg = 1.
  - retired increments once.
- beq 00000110:
  - With alu_zero = 1 in BRANCH: pc_write = 1, pc_src = 1.
  - Repeat with alu_zero = 0: pc_write = 0.
  - bne 00000100 gives the inverse.
  - Each branch retires.
- Bundle 00000000:
  - DECODE→FAULT, fault = 1, fault_cause = 01.
  - Outputs stay 0 for 20 cycles.
  - rst high 1 cycle returns to FETCH with retired = 0.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH:
  - FAULT after exactly 4 FETCH cycles, cause 10.
  - Rerun with mem_ready = 1 on the 4th cycle: DECODE, no fault.
- Assert rst during a MEM wait of a sw:
  - Next state FETCH, mem_we = 0.
  - retired unchanged from its reset value 0.
  - No write completes.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, bundle bit
// positions, PC source selects and fault causes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExec   = 4'd2,
        StAddr   = 4'd3,
        StMem    = 4'd4,
        StWb     = 4'd5,
        StBranch = 4'd6,
        StJump   = 4'd7,
        StFault  = 4'd8
    } state_t;

    localparam int unsigned SigAluSrc   = 7;
    localparam int unsigned SigMemToReg = 6;
    localparam int unsigned SigRegWrite = 5;
    localparam int unsigned SigMemRead  = 4;
    localparam int unsigned SigMemWrite = 3;
    localparam int unsigned SigBranch   = 2;
    localparam int unsigned SigEq       = 1;
    localparam int unsigned SigGoto     = 0;

    localparam logic [1:0] PcSrcPlus4  = 2'd0;
    localparam logic [1:0] PcSrcBranch = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    // Only the bundle bits consulted after DECODE are kept.
    typedef struct packed {
        logic alu_src;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic eq;
    } ctrl_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles and flags the last permitted one.
module mc_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the MIPS core: per-state datapath enables,
// memory-wait watchdog, illegal-instruction fault and retired-instruction count.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          signals,
    input  logic                reg_res,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                ir_write,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                alu_src,
    output logic                alu_sub,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                fault,
    output logic [1:0]          fault_cause,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state
);

    state_t                state_q, state_d;
    ctrl_t                 ctrl_q;
    logic                  reg_res_q;
    logic [1:0]            cause_q, cause_d;
    logic [RETIRE_W-1:0]   retired_q;
    logic                  retire;
    logic                  wait_en;
    logic                  wait_clr;
    logic                  expired;

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (wait_clr),
        .en_i      (wait_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        retire  = 1'b0;
        wait_en = 1'b0;
        unique case (state_q)
            StFetch: begin
                // mem_ready beats the watchdog in the same cycle
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (expired) begin
                    state_d = StFault;
                    cause_d = CauseTimeout;
                end else begin
                    wait_en = 1'b1;
                end
            end
            StDecode: begin
                if (signals[SigGoto]) begin
                    state_d = StJump;
                end else if (signals[SigBranch]) begin
                    state_d = StBranch;
                end else if (signals[SigMemRead] || signals[SigMemWrite]) begin
                    state_d = StAddr;
                end else if (signals[SigRegWrite]) begin
                    state_d = StExec;
                end else begin
                    state_d = StFault;
                    cause_d = CauseIllegal;
                end
            end
            StExec: state_d = StWb;
            StAddr: state_d = StMem;
            StMem: begin
                if (mem_ready) begin
                    if (ctrl_q.mem_read) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else if (expired) begin
                    state_d = StFault;
                    cause_d = CauseTimeout;
                end else begin
                    wait_en = 1'b1;
                end
            end
            StWb, StBranch, StJump: begin
                retire  = 1'b1;
                state_d = StFetch;
            end
            StFault: state_d = StFault;
            default: state_d = StFetch;
        endcase
    end

    assign wait_clr = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            ctrl_q    <= '0;
            reg_res_q <= 1'b0;
            cause_q   <= CauseNone;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == StDecode) begin
                ctrl_q    <= '{alu_src:    signals[SigAluSrc],
                              mem_to_reg: signals[SigMemToReg],
                              mem_read:   signals[SigMemRead],
                              mem_write:  signals[SigMemWrite],
                              eq:         signals[SigEq]};
                reg_res_q <= reg_res;
            end
            if (retire) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PcSrcPlus4;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        alu_src    = 1'b0;
        alu_sub    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        fault      = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            StExec: alu_src = ctrl_q.alu_src;
            StAddr: alu_src = 1'b1;
            StMem: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = ctrl_q.mem_write;
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = ctrl_q.mem_to_reg;
                reg_dst    = reg_res_q;
            end
            StBranch: begin
                alu_sub  = 1'b1;
                pc_src   = PcSrcBranch;
                pc_write = ctrl_q.eq ? alu_zero : ~alu_zero;
            end
            StJump: begin
                pc_src   = PcSrcJump;
                pc_write = 1'b1;
            end
            StFault: fault = 1'b1;
            default: ;
        endcase
    end

    assign fault_cause = cause_q;
    assign retired     = retired_q;
    assign state       = state_q;

endmodule
